// File: rtl/float_div_seq_pkg.sv
// Shared float definitions: FSM state encoding and format-size helpers.
package float_div_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_NORM   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic int float_size(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int exp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/float_div_seq_unpack.sv
// Combinational split of a packed float into sign, exponent and fraction.
module float_div_seq_unpack
   import float_div_seq_pkg::*;
#(
   parameter  int MANTISSA_SIZE = 23,
   parameter  int EXPONENT_SIZE = 8,
   localparam int FLOAT_SIZE    = float_size(EXPONENT_SIZE, MANTISSA_SIZE)
) (
   input  logic [FLOAT_SIZE-1:0]    f,
   output logic                     sign_o,
   output logic [EXPONENT_SIZE-1:0] exp_o,
   output logic [MANTISSA_SIZE-1:0] frac_o
);

   assign sign_o = f[FLOAT_SIZE-1];
   assign exp_o  = f[FLOAT_SIZE-2 -: EXPONENT_SIZE];
   assign frac_o = f[MANTISSA_SIZE-1:0];

endmodule

// File: rtl/float_div_seq.sv
// Sequential float divider: restoring division, one quotient bit per clock,
// truncated result, no special-value handling.
module float_div_seq
   import float_div_seq_pkg::*;
#(
   parameter  int MANTISSA_SIZE = 23,
   parameter  int EXPONENT_SIZE = 8,
   localparam int FLOAT_SIZE    = float_size(EXPONENT_SIZE, MANTISSA_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [FLOAT_SIZE-1:0] s_a,
   input  logic [FLOAT_SIZE-1:0] s_b,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FLOAT_SIZE-1:0] m_data
);

   localparam int M  = MANTISSA_SIZE;
   localparam int E  = EXPONENT_SIZE;
   localparam int CW = $clog2(M + 2);
   localparam logic [CW-1:0] LAST = CW'(M + 1);
   localparam logic [E-1:0]  BIAS = E'(exp_bias(E));

   logic         a_sign, b_sign;
   logic [E-1:0] a_exp, b_exp;
   logic [M-1:0] a_frac, b_frac;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [M+1:0]    rem_q, rem_d;
   logic [M:0]      div_q, div_d;
   logic [M+1:0]    quo_q, quo_d;
   logic            sign_q, sign_d;
   logic [E-1:0]    exp_q, exp_d;
   logic [FLOAT_SIZE-1:0] m_data_q, m_data_d;

   logic [M+1:0] div_ext, rem_sel;
   logic         ge;

   float_div_seq_unpack #(
      .MANTISSA_SIZE(M),
      .EXPONENT_SIZE(E)
   ) u_unpack_a (
      .f      (s_a),
      .sign_o (a_sign),
      .exp_o  (a_exp),
      .frac_o (a_frac)
   );

   float_div_seq_unpack #(
      .MANTISSA_SIZE(M),
      .EXPONENT_SIZE(E)
   ) u_unpack_b (
      .f      (s_b),
      .sign_o (b_sign),
      .exp_o  (b_exp),
      .frac_o (b_frac)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (s_valid)       state_d = ST_DIVIDE;
         ST_DIVIDE: if (cnt_q == LAST) state_d = ST_NORM;
         ST_NORM:                      state_d = ST_DONE;
         ST_DONE:   if (m_ready)       state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state_q == ST_IDLE);
      m_valid = (state_q == ST_DONE);
   end

   assign m_data = m_data_q;

   always_comb begin
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      div_d    = div_q;
      quo_d    = quo_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      m_data_d = m_data_q;
      div_ext  = {1'b0, div_q};
      ge       = (rem_q >= div_ext);
      rem_sel  = ge ? (rem_q - div_ext) : rem_q;
      unique case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               sign_d = a_sign ^ b_sign;
               exp_d  = a_exp - b_exp + BIAS;
               rem_d  = {2'b01, a_frac};
               div_d  = {1'b1, b_frac};
               quo_d  = '0;
               cnt_d  = '0;
            end
         end
         ST_DIVIDE: begin
            // Partial remainder stays below 2*divisor, so the shift never overflows.
            rem_d = rem_sel << 1;
            quo_d = {quo_q[M:0], ge};
            cnt_d = cnt_q + CW'(1);
         end
         ST_NORM: begin
            if (quo_q[M+1])
               m_data_d = {sign_q, exp_q, quo_q[M:1]};
            else
               m_data_d = {sign_q, exp_q - E'(1), quo_q[M-1:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         quo_q    <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         m_data_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         quo_q    <= quo_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         m_data_q <= m_data_d;
      end
   end

endmodule

// File: tb/tb_float_div_seq.sv
// Self-checking bench for float_div_seq: directed cases, stall, reset abort
// and a randomized back-to-back stream against an integer reference model.
module tb_float_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_a;
   logic [31:0] s_b;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   float_div_seq dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_a     (s_a),
      .s_b     (s_b),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Truncated quotient of two normal singles, straight from the format rules.
   function automatic logic [31:0] ref_div(input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned sa, sb, q, frac;
      int e;
      logic [7:0] e8;
      sa = 64'h800000 | longint'(a & 32'h7FFFFF);
      sb = 64'h800000 | longint'(b & 32'h7FFFFF);
      q  = (sa << 24) / sb;
      e  = int'((a >> 23) & 32'hFF) - int'((b >> 23) & 32'hFF) + 127;
      if (q >= 64'h1000000) begin
         frac = (q >> 1) & 64'h7FFFFF;
      end else begin
         frac = q & 64'h7FFFFF;
         e = e - 1;
      end
      e8 = 8'(e);
      return {a[31] ^ b[31], e8, 23'(frac)};
   endfunction

   function automatic logic [31:0] rnd_float();
      logic [31:0] f;
      f        = $urandom;
      f[30:23] = 8'($urandom_range(1, 254));
      return f;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      s_a = a;
      s_b = b;
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("issue_timeout", 32'(s_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // lat counts clock cycles from the accepting edge to the first cycle
   // in which m_valid is seen high.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!m_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!m_valid) chk("valid_timeout", 32'(m_valid), 32'd1);
   endtask

   task automatic take(output logic [31:0] res);
      res = m_data;
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat;
      logic [31:0] res;
      issue(a, b);
      wait_valid(lat);
      take(res);
      chk(tag, res, exp);
      chk({tag, "_model"}, res, ref_div(a, b));
   endtask

   initial begin
      int lat;
      int seen;
      logic [31:0] res, held;
      logic [31:0] exp_q[$];
      logic [31:0] ea;
      int issued, got, last_cyc;
      bit change;

      reset   = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_a     = '0;
      s_b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      reset = 1'b0;

      issue(32'h40C00000, 32'h40000000);
      wait_valid(lat);
      chk("lat_6_2", 32'(lat), 32'd27);
      take(res);
      chk("div_6_2", res, 32'h40400000);
      chk("s_ready_after_take", 32'(s_ready), 32'd1);
      chk("m_valid_after_take", 32'(m_valid), 32'd0);
      chk("m_data_kept", m_data, 32'h40400000);

      run_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
      run_op("div_1_1p5", 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA);
      run_op("div_m1_0p5", 32'hBF800000, 32'h3F000000, 32'hC0000000);

      // Consumer stall with intruding s_valid pulses.
      issue(32'h40C00000, 32'h40000000);
      wait_valid(lat);
      held = m_data;
      chk("stall_data", held, 32'h40400000);
      for (int i = 0; i < 10; i++) begin
         s_valid = i[0];
         s_a = 32'h3F800000;
         s_b = 32'h40400000;
         @(negedge clk);
         chk("stall_valid", 32'(m_valid), 32'd1);
         chk("stall_hold", m_data, held);
         chk("stall_s_ready", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      take(res);
      chk("stall_result", res, 32'h40400000);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_valid) seen++;
      end
      chk("stall_no_extra_op", 32'(seen), 32'd0);

      // Reset in the middle of DIVIDE drops the operation.
      issue(32'h40C00000, 32'h40000000);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_s_ready", 32'(s_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_valid) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000);

      // Back-to-back random stream.
      @(negedge clk);
      issued   = 0;
      got      = 0;
      last_cyc = -1;
      change   = 1'b0;
      s_a      = rnd_float();
      s_b      = rnd_float();
      s_valid  = 1'b1;
      m_ready  = 1'b1;
      for (int cyc = 0; cyc < 200 * 28 + 200 && got < 200; cyc++) begin
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               chk("stream_unexpected", m_data, 32'h0);
            end else begin
               ea = exp_q.pop_front();
               chk("stream_data", m_data, ea);
            end
            if (last_cyc >= 0) chk("stream_period", 32'(cyc - last_cyc), 32'd28);
            last_cyc = cyc;
            got++;
         end
         if (change) begin
            change = 1'b0;
            if (issued < 200) begin
               s_a = rnd_float();
               s_b = rnd_float();
            end else begin
               s_valid = 1'b0;
            end
         end
         if (s_ready && s_valid) begin
            exp_q.push_back(ref_div(s_a, s_b));
            issued++;
            change = 1'b1;
         end
         @(negedge clk);
      end
      chk("stream_count", 32'(got), 32'd200);
      s_valid = 1'b0;
      m_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
